// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit. It issues sequential PC requests with two credits,
// keeps in-order responses in a 2-deep hold queue, and handles redirects and faults.
module instruction_fetch_unit #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [INST_WIDTH-1:0] mem_resp_data,
  input  logic                  mem_resp_err,
  output logic                  buf_write_en,
  output logic [INST_WIDTH-1:0] buf_data,
  input  logic                  buf_is_full,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  fetch_fault,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FAULT} state_t;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   pc, pc_nx;
  logic [1:0]              outstanding, out_nx;
  logic [1:0]              hold_count, hold_nx;
  logic [1:0]              drop_count, drop_nx;
  logic                    fault, fault_nx;
  logic [INST_WIDTH-1:0]   q0, q1;
  logic                    credit, accept, resp, push, pop;
  logic [1:0]              wpos;

  // A response with nothing outstanding is not ours and is ignored.
  assign resp   = mem_resp_valid && (outstanding != 2'd0);
  assign credit = (3'(outstanding) + 3'(hold_count)) < 3'd2;

  assign mem_req_valid = (state == RUN) && fetch_en && credit && !redirect_valid;
  assign mem_req_addr  = pc;
  assign accept        = mem_req_valid && mem_req_ready;

  assign buf_write_en = (hold_count != 2'd0) && !buf_is_full &&
                        ((state == RUN) || (state == IDLE));
  assign buf_data     = q0;
  assign pop          = buf_write_en;
  assign push         = resp && (state == RUN) && !mem_resp_err && !redirect_valid;
  assign wpos         = hold_count - 2'(pop);

  assign fetch_pc    = pc;
  assign fetch_fault = fault;
  assign busy        = (outstanding != 2'd0) || (hold_count != 2'd0);

  always_comb begin
    state_nx = state;
    pc_nx    = accept ? pc + ADDR_WIDTH'(4) : pc;
    out_nx   = outstanding + 2'(accept) - 2'(resp);
    hold_nx  = hold_count - 2'(pop) + 2'(push);
    drop_nx  = drop_count;
    fault_nx = fault;
    if (redirect_valid) begin
      // Everything still in flight, including a response arriving now, is stale.
      pc_nx    = redirect_pc & ~ADDR_WIDTH'(3);
      hold_nx  = 2'd0;
      drop_nx  = out_nx;
      fault_nx = 1'b0;
      state_nx = (out_nx != 2'd0) ? DRAIN : RUN;
    end else begin
      case (state)
        IDLE: if (fetch_en) state_nx = RUN;
        RUN: begin
          if (resp && mem_resp_err) begin
            fault_nx = 1'b1;
            hold_nx  = 2'd0;
            state_nx = FAULT;
          end else if (!fetch_en && out_nx == 2'd0) begin
            state_nx = IDLE;
          end
        end
        DRAIN: begin
          if (resp) begin
            drop_nx = drop_count - 2'd1;
            if (drop_count == 2'd1) state_nx = fetch_en ? RUN : IDLE;
          end
        end
        FAULT: ;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= 2'd0;
      hold_count  <= 2'd0;
      drop_count  <= 2'd0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      outstanding <= out_nx;
      hold_count  <= hold_nx;
      drop_count  <= drop_nx;
      fault       <= fault_nx;
    end
  end

  // Hold queue storage: q0 is the head, and a pop shifts q1 forward.
  always_ff @(posedge clk) begin
    if (pop) q0 <= q1;
    if (push) begin
      if (wpos == 2'd0) q0 <= mem_resp_data;
      else              q1 <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit. A queue-based reference model feeds
// a scoreboard of expected buffer words, and a monitor checks every buffer write.
module tb_instruction_fetch_unit;
  localparam int IW = 32;
  localparam int AW = 8;
  localparam logic [AW-1:0] RPC = 8'h20;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_FAULT = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready = 1'b0;
  logic          mem_resp_valid = 1'b0;
  logic [IW-1:0] mem_resp_data = '0;
  logic          mem_resp_err = 1'b0;
  logic          buf_write_en;
  logic [IW-1:0] buf_data;
  logic          buf_is_full = 1'b0;
  logic [AW-1:0] fetch_pc;
  logic          fetch_fault;
  logic          busy;

  instruction_fetch_unit #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .buf_write_en(buf_write_en), .buf_data(buf_data), .buf_is_full(buf_is_full),
    .fetch_pc(fetch_pc), .fetch_fault(fetch_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    bit live;
  } req_t;

  int            checks = 0;
  int            errors = 0;
  req_t          inflight[$];
  logic [IW-1:0] sb[$];
  int            mem_pend[$];
  int            mode;
  int            pc;
  bit            fault;
  bit            popped;
  logic [IW-1:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] mem_word(input int a);
    return (32'(a) * 32'h0101_0101) ^ 32'hA5C3_0F96;
  endfunction

  function automatic bit pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  task automatic model_reset();
    inflight.delete();
    sb.delete();
    mem_pend.delete();
    mode  = M_IDLE;
    pc    = int'(RPC);
    fault = 1'b0;
  endtask

  task automatic kill_inflight();
    foreach (inflight[i]) inflight[i].live = 1'b0;
  endtask

  task automatic model_step();
    int   held;
    int   n_dead;
    bit   exp_req;
    bit   exp_wr;
    bit   accept;
    bit   resp;
    req_t r;
    held    = sb.size() + (popped ? 1 : 0);
    exp_req = (mode == M_RUN) && fetch_en && (inflight.size() + held < 2) && !redirect_valid;
    exp_wr  = (held != 0) && !buf_is_full && (mode == M_RUN || mode == M_IDLE);
    check("mem_req_valid", 64'(mem_req_valid), 64'(exp_req));
    check("buf_write_en", 64'(buf_write_en), 64'(exp_wr));
    check("fetch_pc", 64'(fetch_pc), 64'(pc));
    if (exp_req) check("mem_req_addr", 64'(mem_req_addr), 64'(pc));
    check("fetch_fault", 64'(fetch_fault), 64'(fault));
    check("busy", 64'(busy), 64'(inflight.size() + held != 0));
    // The memory answers whatever the DUT actually handed it.
    if (mem_req_valid && mem_req_ready) mem_pend.push_back(int'(mem_req_addr));
    accept = exp_req && mem_req_ready;
    resp   = mem_resp_valid && (inflight.size() != 0);
    if (resp) begin
      r = inflight.pop_front();
      if (!redirect_valid && mode == M_RUN && r.live && !mem_resp_err)
        sb.push_back(mem_word(r.addr));
    end
    if (accept) begin
      r.addr = pc;
      r.live = 1'b1;
      inflight.push_back(r);
      pc = (pc + 4) % (1 << AW);
    end
    if (redirect_valid) begin
      pc = int'(redirect_pc) & 'hFC;
      sb.delete();
      kill_inflight();
      fault = 1'b0;
      mode  = (inflight.size() != 0) ? M_DRAIN : M_RUN;
    end else begin
      case (mode)
        M_IDLE: if (fetch_en) mode = M_RUN;
        M_RUN: begin
          if (resp && mem_resp_err) begin
            fault = 1'b1;
            sb.delete();
            kill_inflight();
            mode = M_FAULT;
          end else if (!fetch_en && inflight.size() == 0) begin
            mode = M_IDLE;
          end
        end
        M_DRAIN: begin
          n_dead = 0;
          foreach (inflight[i]) if (!inflight[i].live) n_dead++;
          if (n_dead == 0) mode = fetch_en ? M_RUN : M_IDLE;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    popped = 1'b0;
    forever begin
      @(negedge clk);
      popped = 1'b0;
      if (buf_write_en) begin
        popped = 1'b1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL buf_write unexpected write data=%0h required=none at %0t", buf_data, $time);
        end else begin
          mon_e = sb.pop_front();
          if (buf_data !== mon_e) begin
            errors++;
            $display("FAIL buf_data actual=%0h required=%0h at %0t", buf_data, mon_e, $time);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'(0));
    check({tag, ".buf_write_en"}, 64'(buf_write_en), 64'(0));
    check({tag, ".fetch_fault"}, 64'(fetch_fault), 64'(0));
    check({tag, ".busy"}, 64'(busy), 64'(0));
    check({tag, ".fetch_pc"}, 64'(fetch_pc), 64'(RPC));
  endtask

  task automatic cycle(input int p_ready, input int p_resp, input int p_full, input int p_redir,
                       input int p_err, input int p_fenoff, input int p_rst, input int force_pc);
    int a;
    @(posedge clk);
    #1;
    reset_n       = 1'b1;
    mem_req_ready = pct(p_ready);
    fetch_en      = !pct(p_fenoff);
    buf_is_full   = pct(p_full);
    if (force_pc >= 0) begin
      redirect_valid = 1'b1;
      redirect_pc    = AW'(force_pc);
    end else begin
      redirect_valid = pct(p_redir);
      redirect_pc    = pct(25) ? AW'(8'hFD) : AW'($urandom);
    end
    if (mem_pend.size() != 0 && pct(p_resp)) begin
      a              = mem_pend.pop_front();
      mem_resp_valid = 1'b1;
      mem_resp_err   = pct(p_err);
      mem_resp_data  = mem_resp_err ? IW'($urandom) : mem_word(a);
    end else if (mem_pend.size() == 0 && pct(5)) begin
      mem_resp_valid = 1'b1;
      mem_resp_err   = 1'($urandom);
      mem_resp_data  = IW'($urandom);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
      mem_resp_data  = IW'($urandom);
    end
    if (pct(p_rst)) begin
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    // Streaming with single-cycle memory latency.
    repeat (60) cycle(100, 100, 0, 0, 0, 0, 0, -1);
    // Buffer backpressure, then release.
    repeat (10) cycle(100, 100, 100, 0, 0, 0, 0, -1);
    repeat (20) cycle(100, 100, 0, 0, 0, 0, 0, -1);
    // Build up two outstanding requests, then redirect near the top of the space.
    repeat (4) cycle(100, 0, 0, 0, 0, 0, 0, -1);
    cycle(100, 0, 0, 0, 0, 0, 0, 'hFC);
    repeat (20) cycle(100, 100, 0, 0, 0, 0, 0, -1);
    // Error response, sit in fault, then recover through a redirect.
    repeat (3) cycle(100, 100, 0, 0, 100, 0, 0, -1);
    repeat (6) cycle(100, 100, 0, 0, 0, 0, 0, -1);
    cycle(100, 100, 0, 0, 0, 0, 0, 'h40);
    repeat (20) cycle(100, 100, 0, 0, 0, 0, 0, -1);
    // Reset in the middle of streaming.
    repeat (5) cycle(100, 100, 0, 0, 0, 0, 0, -1);
    cycle(100, 100, 0, 0, 0, 0, 100, -1);
    repeat (20) cycle(100, 100, 0, 0, 0, 0, 0, -1);
    // Fully random traffic.
    repeat (3000) cycle(70, 60, 30, 3, 3, 10, 1, -1);
    repeat (10) cycle(100, 100, 0, 0, 0, 0, 0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameters: INST_WIDTH, default 32, instruction word width; ADDR_WIDTH, default 32, PC and memory address width; RESET_PC, default 0, first fetch address after reset.
REQ-002 SHALL have ports: clk input 1, sole clock, rising edge.
REQ-003 SHALL have port reset_n input 1, asynchronous active-low reset.
REQ-004 SHALL have port fetch_en input 1, permits new memory requests while high.
REQ-005 SHALL have ports redirect_valid input 1 and redirect_pc input ADDR_WIDTH, branch/exception PC change.
REQ-006 SHALL have ports mem_req_valid output 1, mem_req_addr output ADDR_WIDTH, mem_req_ready input 1, instruction memory request channel.
REQ-007 SHALL have ports mem_resp_valid input 1, mem_resp_data input INST_WIDTH, mem_resp_err input 1, in-order memory response channel, no backpressure.
REQ-008 SHALL have ports buf_write_en output 1, buf_data output INST_WIDTH, buf_is_full input 1, write side of the instruction buffer.
REQ-009 SHALL have ports fetch_pc output ADDR_WIDTH (next request address), fetch_fault output 1, busy output 1 (outstanding requests or held words nonzero).

Function
REQ-010 SHALL implement states IDLE, RUN, DRAIN, FAULT.
REQ-011 IDLE -> RUN when fetch_en=1; RUN -> IDLE when fetch_en=0 and no requests are outstanding.
REQ-012 SHALL hold at most 2 requests outstanding and a 2-entry response hold queue; new request permitted only when outstanding + hold_count < 2.
REQ-013 mem_req_valid SHALL be asserted in RUN when fetch_en=1, the REQ-012 credit is available, and redirect_valid=0; mem_req_addr SHALL equal fetch_pc.
REQ-014 A request SHALL be accepted on a cycle with mem_req_valid=1 and mem_req_ready=1; fetch_pc SHALL then increment by 4, wrapping modulo 2^ADDR_WIDTH; addr stays stable until acceptance except on redirect.
REQ-015 Each mem_resp_valid=1 with mem_resp_err=0 in RUN SHALL enqueue mem_resp_data and decrement outstanding in the same cycle.
REQ-016 buf_write_en SHALL be combinational: 1 iff hold_count != 0, buf_is_full=0, and state is RUN or IDLE; buf_data SHALL be the queue head; head pops on that cycle.
REQ-017 buf_write_en SHALL never be 1 while buf_is_full=1; words SHALL reach the buffer in request order, none dropped or duplicated except by REQ-018/020.
REQ-018 redirect_valid=1 SHALL: load fetch_pc with redirect_pc (low 2 bits forced 0), clear the hold queue, set drop count = outstanding (including any request accepted that same cycle), and enter DRAIN if drop count nonzero, otherwise RUN.
REQ-019 In DRAIN each response SHALL be discarded and decrement drop count; no requests issued; drop count reaching 0 -> RUN (or IDLE if fetch_en=0).
REQ-020 A response with mem_resp_err=1 in RUN SHALL be discarded, assert fetch_fault, and enter FAULT after discarding the hold queue; later responses are discarded.
REQ-021 FAULT SHALL issue no requests and keep fetch_fault=1 until redirect_valid=1, which applies REQ-018 and clears fetch_fault.
REQ-022 A response coincident with redirect_valid SHALL be discarded and counted as a drop.
REQ-023 A response arriving with outstanding=0 SHALL be ignored.

Reset
REQ-024 reset_n=0 SHALL immediately set state IDLE, fetch_pc=RESET_PC, outstanding=0, hold_count=0, drop count=0, fetch_fault=0, busy=0, mem_req_valid=0, buf_write_en=0.
REQ-025 Reset mid-operation SHALL abandon all in-flight requests; responses after release with outstanding=0 fall under REQ-023.

Verification
REQ-026 Streaming: fetch_en=1, mem_req_ready=1, 1-cycle response latency, buf_is_full=0 -> addresses 0,4,8,... and buffer receives data in order, each word one cycle after its response.
REQ-027 Backpressure: buf_is_full=1 for 10 cycles -> at most 2 requests issued, hold_count=2, buf_write_en=0; on release both words written on consecutive cycles.
REQ-028 Redirect with 2 outstanding: redirect_pc=0x100 -> DRAIN, both old responses dropped, next request addr 0x100, no stale word reaches buffer.
REQ-029 Error: third response has mem_resp_err=1 -> fetch_fault=1, no further requests; redirect_pc=0x40 -> fetch_fault=0, fetch resumes at 0x40.
REQ-030 Wrap: ADDR_WIDTH=8, redirect_pc=0xFC -> requests at 0xFC then 0x00.
REQ-031 Async reset asserted mid-stream between clock edges -> all outputs at REQ-024 values before the next edge; after release first request at RESET_PC.
